// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches a word, applies one single-bit shift or rotate
// per clock for the requested amount, then returns the result over a valid/ready handshake.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_rot,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lost,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_count;
    logic             r_dir;
    logic             r_rot;
    logic             r_inReady;
    logic             r_outValid;
    logic             r_lost;

    logic             w_outBit;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;

    // One-bit shifter stage; rotate mode feeds the departing bit back in at the far end.
    always_comb begin
        w_outBit  = r_dir ? r_work[0] : r_work[WIDTH-1];
        w_fill    = r_rot & w_outBit;
        w_shifted = r_dir ? {w_fill, r_work[WIDTH-1:1]} : {r_work[WIDTH-2:0], w_fill};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_rot      <= 1'b0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_lost     <= 1'b0;
        end else if (abort && (r_state != IDLE)) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_inReady) begin
                        r_inReady <= 1'b1;
                    end else if (in_valid) begin
                        r_work    <= in_data;
                        r_dir     <= in_dir;
                        r_rot     <= in_rot;
                        r_count   <= in_amt;
                        r_inReady <= 1'b0;
                        r_lost    <= 1'b0;
                        if (in_amt == '0) begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count - 1'b1;
                    if (!r_rot && w_outBit) begin
                        r_lost <= 1'b1;
                    end
                    // Count only reaches zero on the final shift, so it cannot wrap.
                    if (r_count == AMT_W'(1)) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_work;
    assign out_lost  = r_lost;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: an arithmetic result/timing model checked every
// cycle, plus hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int AMT_W = 3;
    localparam int SH    = 1 << AMT_W;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_dir    = 1'b0;
    logic             in_rot    = 1'b0;
    logic [AMT_W-1:0] in_amt    = '0;
    logic             abort     = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_lost;
    logic             busy;

    int checks     = 0;
    int failures   = 0;
    int busyCycles = 0;

    bit               mBusy  = 1'b0;
    bit               mReady = 1'b0;
    bit               mValid = 1'b0;
    logic [WIDTH-1:0] mData  = '0;
    logic             mLost  = 1'b0;
    int               cycle  = 0;
    int               mDue   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .in_amt    (in_amt),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lost  (out_lost),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Whole-operation result computed arithmetically rather than bit by bit.
    function automatic void modelResult(input logic [WIDTH-1:0] d, input logic dir, input logic rot,
                                        input logic [AMT_W-1:0] amt,
                                        output logic [WIDTH-1:0] res, output logic lost);
        int v;
        int k;
        v = int'(d);
        if (rot) begin
            k = int'(amt) % WIDTH;
            if (!dir) v = (v << k) | (v >> (WIDTH - k));
            else      v = (v >> k) | (v << (WIDTH - k));
            res  = v[WIDTH-1:0];
            lost = 1'b0;
        end else if (!dir) begin
            v    = v << amt;
            res  = v[WIDTH-1:0];
            lost = (v >> WIDTH) != 0;
        end else begin
            v    = (v << SH) >> amt;
            res  = v[SH+WIDTH-1:SH];
            lost = (v & ((1 << SH) - 1)) != 0;
        end
    endfunction

    // Timeline model: a request accepted at cycle N is due at cycle N+amt.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy  = 1'b0;
            mReady = 1'b0;
            mValid = 1'b0;
        end else begin
            cycle++;
            if (mBusy && abort) begin
                mBusy  = 1'b0;
                mValid = 1'b0;
                mReady = 1'b1;
            end else if (!mBusy) begin
                if (!mReady) begin
                    mReady = 1'b1;
                end else if (in_valid) begin
                    modelResult(in_data, in_dir, in_rot, in_amt, mData, mLost);
                    mBusy  = 1'b1;
                    mReady = 1'b0;
                    mDue   = cycle + int'(in_amt);
                    mValid = (in_amt == '0);
                end
            end else if (mValid) begin
                if (out_ready) begin
                    mBusy  = 1'b0;
                    mValid = 1'b0;
                    mReady = 1'b1;
                end
            end else if (cycle >= mDue) begin
                mValid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (busy) busyCycles++;
        checkOutput("cmp_in_ready", int'(in_ready), int'(mReady));
        checkOutput("cmp_out_valid", int'(out_valid), int'(mValid));
        checkOutput("cmp_busy", int'(busy), int'(mBusy));
        if (mValid) begin
            checkOutput("cmp_out_data", int'(out_data), int'(mData));
            checkOutput("cmp_out_lost", int'(out_lost), int'(mLost));
        end
    end

    // Called at a negedge; leaves at the negedge after the output handshake.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic dir, input logic rot,
                                 input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] expData,
                                 input logic expLost, input string name);
        int waitCnt = 0;
        int lat     = 0;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({name, "_ready"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_dir    = dir;
        in_rot    = rot;
        in_amt    = amt;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        in_dir   = ~dir;
        in_rot   = ~rot;
        in_amt   = amt + 3'd3;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_latency"}, lat, int'(amt));
        checkOutput({name, "_data"}, int'(out_data), int'(expData));
        checkOutput({name, "_lost"}, int'(out_lost), int'(expLost));
        @(negedge clk);
        checkOutput({name, "_released"}, int'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_lost", int'(out_lost), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_in_ready", int'(in_ready), 1);

        // Asynchronous reset in the middle of a shift sequence.
        in_valid  = 1'b1;
        in_data   = 4'b0011;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        in_amt    = 3'd5;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", int'(out_valid), 0);
        checkOutput("async_out_data", int'(out_data), 0);
        checkOutput("async_in_ready", int'(in_ready), 0);
        checkOutput("async_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel2_in_ready", int'(in_ready), 1);

        busyCycles = 0;
        applyStimulus(4'b0011, 1'b0, 1'b0, 3'd2, 4'b1100, 1'b0, "left2");
        checkOutput("left2_busyCycles", busyCycles, 3);

        applyStimulus(4'b1001, 1'b1, 1'b1, 3'd1, 4'b1100, 1'b0, "rotr1");
        applyStimulus(4'b1001, 1'b0, 1'b0, 3'd1, 4'b0010, 1'b1, "logl1");
        applyStimulus(4'b0101, 1'b0, 1'b0, 3'd0, 4'b0101, 1'b0, "amt0");
        applyStimulus(4'b1111, 1'b0, 1'b0, 3'd7, 4'b0000, 1'b1, "logl7");
        applyStimulus(4'b1000, 1'b0, 1'b1, 3'd5, 4'b0001, 1'b0, "rotl5");
        applyStimulus(4'b1011, 1'b1, 1'b0, 3'd2, 4'b0010, 1'b1, "logr2");
        applyStimulus(4'b0110, 1'b1, 1'b1, 3'd6, 4'b1001, 1'b0, "rotr6");

        // Backpressure with a second request already waiting on in_valid.
        in_valid  = 1'b1;
        in_data   = 4'b0110;
        in_dir    = 1'b0;
        in_rot    = 1'b1;
        in_amt    = 3'd1;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 4'b0001;
        in_rot  = 1'b0;
        in_amt  = 3'd2;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", lat, 1);
        checkOutput("bp_data", int'(out_data), 4'b1100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_data", int'(out_data), 4'b1100);
            checkOutput("bp_hold_in_ready", int'(in_ready), 0);
            checkOutput("bp_hold_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_idle_out_valid", int'(out_valid), 0);
        checkOutput("bp_idle_busy", int'(busy), 0);
        checkOutput("bp_idle_in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_next_busy", int'(busy), 1);
        checkOutput("bp_next_in_ready", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_next_latency", lat, 2);
        checkOutput("bp_next_data", int'(out_data), 4'b0100);
        checkOutput("bp_next_lost", int'(out_lost), 0);
        @(negedge clk);

        // Abort while two shifts remain, colliding with a new request.
        in_valid  = 1'b1;
        in_data   = 4'b1010;
        in_dir    = 1'b1;
        in_rot    = 1'b0;
        in_amt    = 3'd4;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_amt   = 3'd1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_out_lost", int'(out_lost), 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_quiet_out_valid", int'(out_valid), 0);
        end
        applyStimulus(4'b0011, 1'b1, 1'b1, 3'd3, 4'b0110, 1'b0, "postAbort");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the one-bit logical shifter datapath.
- Accepts a WIDTH-bit word, a direction, a mode and a shift amount, then applies one single-bit shift per clock, amt times.
- Returns the result over a valid/ready handshake with backpressure.
- Sits between a requesting master (sequencer/test driver) and the shifter stage; owns the working register, iteration counter and handshake state.

Parameters:
- WIDTH, 4, data word width in bits (≥2).
- AMT_W, 3, width of the shift-amount field; amounts 0..2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request (registered).
- in_data  input  WIDTH  word to shift.
- in_dir  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- in_rot  input  1  0 = logical (zero fill), 1 = rotate.
- in_amt  input  AMT_W  number of single-bit shifts.
- abort  input  1  synchronous cancel of the current operation.
- out_valid  output  1  result available (registered).
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result (registered).
- out_lost  output  1  logical mode only: at least one 1 was shifted out.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=0, out_valid=0, out_data=0, out_lost=0, counter=0, busy=0.
- First rising edge after rst_n releases sets in_ready=1.
- States:
  - IDLE: in_ready=1. At an edge with in_valid&in_ready, latch in_data/dir/rot into the working register and load counter=in_amt; in_ready←0, out_lost←0. Go to DONE (out_valid←1) if in_amt==0, else go to SHIFT.
  - SHIFT: each edge performs one 1-bit shift of the working register and decrements the counter.
    - dir=0: bit0 fill; dir=1: bit WIDTH-1 fill. Fill bit = 0 in logical mode, the bit shifted out in rotate mode.
    - Logical mode: if the bit shifted out is 1, out_lost←1 (sticky for the operation).
    - When counter reaches 0 on this edge: go to DONE and set out_valid←1.
  - DONE: out_valid=1. out_data and out_lost stay stable until the edge with out_valid&out_ready; that edge sets out_valid←0, in_ready←1, state←IDLE.
- Latency:
  - For a request accepted at edge N, out_valid is high after edge N+amt (amt=0: after edge N).
  - No shortcut for large amounts: cycles always equal amt.
- Throughput: the next request can be accepted at the edge after the output handshake at the earliest, so there is a 1-cycle IDLE gap.
- out_data is the working register, visible continuously. It is only meaningful while out_valid=1.
- Width rules:
  - Logical mode with amt ≥ WIDTH yields all zeros.
  - Rotate mode with amt ≥ WIDTH wraps, so the result equals rotation by amt mod WIDTH.
  - The counter never underflows.
- in_valid outside IDLE: ignored. Inputs are sampled only on the accept edge; later changes have no effect.
- abort:
  - In SHIFT or DONE: next edge sets state=IDLE, out_valid=0, in_ready=1. out_data keeps its last value, out_lost←0, and no result is produced.
  - In IDLE: no effect. abort has priority over accept and over the output handshake at the same edge.
- Reset mid-operation: immediate return to the reset values above; the in-flight request is lost.
- out_ready while out_valid=0: ignored.

Test Plan:
1. Reset: hold rst_n=0 mid-SHIFT → out_valid=0, out_data=0, in_ready=0, busy=0 asynchronously; release → in_ready=1 after the first edge.
2. in_data=0011, dir=0, rot=0, amt=2, out_ready=1 → out_valid high after accept+2 edges; out_data=1100, out_lost=0; busy high for 3 cycles in total.
3. in_data=1001, amt=1: with dir=1, rot=1 → 1100, out_lost=0; with dir=0, rot=0 → 0010, out_lost=1.
4. Boundaries:
   - amt=0, in_data=0101 → out_valid after the accept edge, out_data=0101, out_lost=0.
   - amt=7, in_data=1111, dir=0, logical → 0000 after 7 shifts, out_lost=1.
   - amt=5, in_data=1000, dir=0, rotate → 0001.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 → out_data stable, in_ready=0, no new accept. Raise out_ready → IDLE next edge, new accept one edge later.
6. Abort in SHIFT at counter=2, simultaneous with in_valid → IDLE next edge, out_valid never asserted, in_ready=1. The following request completes correctly.
